// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: instruction field layout,
// opcode/condition/shift encodings and FSM state encodings.
package alu_issue_ctrl_pkg;

  localparam int unsigned NREGS  = 16;
  localparam int unsigned INSTR_W = 32;

  // Instruction field bit positions
  localparam int unsigned COND_HI = 31;
  localparam int unsigned COND_LO = 28;
  localparam int unsigned OPC_HI  = 27;
  localparam int unsigned OPC_LO  = 24;
  localparam int unsigned S_BIT   = 23;
  localparam int unsigned RD_HI   = 22;
  localparam int unsigned RD_LO   = 19;
  localparam int unsigned RN_HI   = 18;
  localparam int unsigned RN_LO   = 15;
  localparam int unsigned RM_HI   = 14;
  localparam int unsigned RM_LO   = 11;
  localparam int unsigned SRC_HI  = 10;
  localparam int unsigned SRC_LO  = 8;
  localparam int unsigned SRB_HI  = 7;
  localparam int unsigned SRB_LO  = 3;
  localparam int unsigned IMM_HI  = 15;
  localparam int unsigned IMM_LO  = 0;

  // Opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_ORR  = 4'h3;
  localparam logic [3:0] OP_EOR  = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_MOVI = 4'h6;
  localparam logic [3:0] OP_SHF  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_LDR  = 4'hD;
  localparam logic [3:0] OP_STR  = 4'hE;

  // Condition codes
  localparam logic [3:0] CND_NONE = 4'h0;
  localparam logic [3:0] CND_EQ   = 4'h1;
  localparam logic [3:0] CND_GT   = 4'h2;
  localparam logic [3:0] CND_LT   = 4'h3;
  localparam logic [3:0] CND_GE   = 4'h4;
  localparam logic [3:0] CND_LE   = 4'h5;
  localparam logic [3:0] CND_HI   = 4'h6;
  localparam logic [3:0] CND_LO   = 4'h7;
  localparam logic [3:0] CND_HS   = 4'h8;

  // Shift/rotate control
  localparam logic [2:0] SR_NONE = 3'd0;
  localparam logic [2:0] SR_LSL  = 3'd1;
  localparam logic [2:0] SR_LSR  = 3'd2;
  localparam logic [2:0] SR_ASR  = 3'd3;
  localparam logic [2:0] SR_ROR  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Plain-vector aliases keep the legacy state register a bare logic [1:0]
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] READ = ST_READ;
  localparam logic [1:0] EXEC = ST_EXEC;
  localparam logic [1:0] WB   = ST_WB;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_SHF) || (op == OP_CMP) || (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Handshake, ALU-facing and debug signals of the ALU issue controller.
interface alu_issue_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [3:0]        alu_opcode;
  logic [3:0]        alu_cond;
  logic              alu_s;
  logic [2:0]        alu_sr_cont;
  logic [4:0]        alu_sr_bit;
  logic [15:0]       alu_imm;
  logic [DATA_W-1:0] alu_out;
  logic [3:0]        alu_flags;
  logic              alu_cond_met;
  logic              done;
  logic              wrote;
  logic              illegal;
  logic [3:0]        flags_q;
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output instr_valid, instr, alu_out, alu_flags, alu_cond_met, dbg_addr,
    input  instr_ready, alu_in1, alu_in2, alu_opcode, alu_cond, alu_s,
           alu_sr_cont, alu_sr_bit, alu_imm, done, wrote, illegal, flags_q,
           dbg_data
  );

  modport slave (
    input  instr_valid, instr, alu_out, alu_flags, alu_cond_met, dbg_addr,
    output instr_ready, alu_in1, alu_in2, alu_opcode, alu_cond, alu_s,
           alu_sr_cont, alu_sr_bit, alu_imm, done, wrote, illegal, flags_q,
           dbg_data
  );
endinterface

// File: rtl/alu_regfile.sv
// 16-entry register file: two operand read ports, one debug read port,
// one synchronous write port, asynchronous clear.
module alu_regfile
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [3:0]        rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [3:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) mem_d[i] = mem_q[i];
    if (we) mem_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Reads return the pre-write contents during the write cycle
  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: captures an instruction, reads operands,
// samples the external ALU, and writes back register and NZCV results.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_issue_ctrl_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
  logic [3:0]        alu_opcode_q, alu_opcode_d;
  logic [3:0]        alu_cond_q, alu_cond_d;
  logic              alu_s_q, alu_s_d;
  logic [2:0]        alu_sr_cont_q, alu_sr_cont_d;
  logic [4:0]        alu_sr_bit_q, alu_sr_bit_d;
  logic [15:0]       alu_imm_q, alu_imm_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [3:0]        res_flags_q, res_flags_d;
  logic              res_met_q, res_met_d;
  logic [3:0]        flag_reg_q, flag_reg_d;

  logic [DATA_W-1:0] ra_data, rb_data;
  logic              in_wb, legal, rf_we, flag_we;

  alu_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (ir_q[RN_HI:RN_LO]),
    .ra_data  (ra_data),
    .rb_addr  (ir_q[RM_HI:RM_LO]),
    .rb_data  (rb_data),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data),
    .we       (rf_we),
    .wa       (ir_q[RD_HI:RD_LO]),
    .wd       (res_q)
  );

  // Writeback qualifiers use the decoded copy latched in READ
  assign in_wb   = (state_q == WB);
  assign legal   = op_legal(alu_opcode_q);
  assign rf_we   = in_wb && legal && res_met_q &&
                   (alu_opcode_q != OP_CMP) && (alu_opcode_q != OP_STR);
  assign flag_we = in_wb && legal && res_met_q &&
                   (alu_s_q || (alu_opcode_q == OP_CMP));

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    alu_in1_d     = alu_in1_q;
    alu_in2_d     = alu_in2_q;
    alu_opcode_d  = alu_opcode_q;
    alu_cond_d    = alu_cond_q;
    alu_s_d       = alu_s_q;
    alu_sr_cont_d = alu_sr_cont_q;
    alu_sr_bit_d  = alu_sr_bit_q;
    alu_imm_d     = alu_imm_q;
    res_d         = res_q;
    res_flags_d   = res_flags_q;
    res_met_d     = res_met_q;
    flag_reg_d    = flag_reg_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = READ;
        end
      end
      READ: begin
        alu_in1_d     = ra_data;
        alu_in2_d     = rb_data;
        alu_opcode_d  = ir_q[OPC_HI:OPC_LO];
        alu_cond_d    = ir_q[COND_HI:COND_LO];
        alu_s_d       = ir_q[S_BIT];
        alu_sr_cont_d = ir_q[SRC_HI:SRC_LO];
        alu_sr_bit_d  = ir_q[SRB_HI:SRB_LO];
        alu_imm_d     = ir_q[IMM_HI:IMM_LO];
        state_d       = EXEC;
      end
      EXEC: begin
        res_d       = bus.alu_out;
        res_flags_d = bus.alu_flags;
        res_met_d   = bus.alu_cond_met;
        state_d     = WB;
      end
      WB: begin
        if (flag_we) flag_reg_d = res_flags_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ir_q          <= '0;
      alu_in1_q     <= '0;
      alu_in2_q     <= '0;
      alu_opcode_q  <= '0;
      alu_cond_q    <= '0;
      alu_s_q       <= 1'b0;
      alu_sr_cont_q <= '0;
      alu_sr_bit_q  <= '0;
      alu_imm_q     <= '0;
      res_q         <= '0;
      res_flags_q   <= '0;
      res_met_q     <= 1'b0;
      flag_reg_q    <= '0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      alu_in1_q     <= alu_in1_d;
      alu_in2_q     <= alu_in2_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_cond_q    <= alu_cond_d;
      alu_s_q       <= alu_s_d;
      alu_sr_cont_q <= alu_sr_cont_d;
      alu_sr_bit_q  <= alu_sr_bit_d;
      alu_imm_q     <= alu_imm_d;
      res_q         <= res_d;
      res_flags_q   <= res_flags_d;
      res_met_q     <= res_met_d;
      flag_reg_q    <= flag_reg_d;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.alu_in1     = alu_in1_q;
  assign bus.alu_in2     = alu_in2_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_cond    = alu_cond_q;
  assign bus.alu_s       = alu_s_q;
  assign bus.alu_sr_cont = alu_sr_cont_q;
  assign bus.alu_sr_bit  = alu_sr_bit_q;
  assign bus.alu_imm     = alu_imm_q;
  assign bus.done        = in_wb;
  assign bus.wrote       = rf_we;
  assign bus.illegal     = in_wb && !legal;
  assign bus.flags_q     = flag_reg_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; SHALL be 32 and no other value is supported.
REQ-002 Clocking: one clock, clk; reset rst_n, asynchronous, active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr_ready  out  1  block can accept an instruction.
REQ-007 instr  in  32  instruction word: [31:28] Cond, [27:24] Opcode, [23] S, [22:19] Rd, [18:15] Rn, [14:11] Rm, [10:8] SR_Cont, [7:3] SR_Bit, [2:0] reserved; Immediate = [15:0].
REQ-008 alu_in1, alu_in2  out  32 each  operands R[Rn] and R[Rm].
REQ-009 alu_opcode, alu_cond  out  4 each; alu_s  out  1; alu_sr_cont  out  3; alu_sr_bit  out  5; alu_imm  out  16: decoded fields driven to the ALU.
REQ-010 alu_out  in  32; alu_flags  in  4 (NZCV); alu_cond_met  in  1: combinational ALU results.
REQ-011 done  out  1  one-cycle pulse, instruction retired.
REQ-012 wrote  out  1  qualifies done: Rd was written.
REQ-013 illegal  out  1  qualifies done: opcode unsupported.
REQ-014 flags_q  out  4  architectural NZCV register.
REQ-015 dbg_addr  in  4; dbg_data  out  32  combinational register-file read port.

Function
REQ-016 The block SHALL contain a 16 x 32 register file, all entries writable.
REQ-017 FSM states SHALL be IDLE, READ, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, instr_valid=1 SHALL capture instr into an instruction register and go to READ; otherwise the FSM stays in IDLE.
REQ-019 READ SHALL register alu_in1=R[Rn], alu_in2=R[Rm] and all decoded fields, then go to EXEC.
REQ-020 ALU-facing outputs SHALL be registered and held stable from READ exit until the next READ.
REQ-021 EXEC SHALL sample alu_out, alu_flags, alu_cond_met into holding registers, then go to WB.
REQ-022 Legal opcodes SHALL be 0000-0111, 1011, 1101, 1110; any other opcode is illegal.
REQ-023 WB SHALL write R[Rd]=sampled alu_out iff opcode legal, not 1011 (CMP), not 1110 (STR), and cond_met=1.
REQ-024 flags_q SHALL load sampled alu_flags in WB iff opcode legal, cond_met=1, and (S=1 or opcode=1011).
REQ-025 WB SHALL pulse done for exactly one cycle, with wrote and illegal valid in the same cycle, then return to IDLE.
REQ-026 wrote and illegal SHALL be 0 whenever done=0.
REQ-027 Latency SHALL be exactly 3 cycles: accept edge at cycle 0, done high during cycle 3; next accept no earlier than cycle 4.
REQ-028 If Rd equals Rn or Rm, the next instruction SHALL read the written value; no bypass is needed because WB precedes the next READ.
REQ-029 A dbg_addr read of the register being written SHALL return the old value in the write cycle and the new value afterward.
REQ-030 An illegal opcode SHALL leave registers and flags_q unchanged.
REQ-031 instr_valid asserted outside IDLE SHALL be ignored, not queued.

Reset
REQ-032 rst_n low SHALL asynchronously set: FSM to IDLE, all 16 registers and flags_q to 0, ALU-facing outputs to 0, done/wrote/illegal to 0.
REQ-033 Reset asserted in any non-IDLE state SHALL abort the instruction, with no register or flag write and no done pulse.
REQ-034 The first cycle after reset release SHALL have instr_ready=1.

Structure
REQ-035 A shared package SHALL hold opcode constants (ADD..STR), cond constants (NONE, EQ, GT, LT, GE, LE, HI, LO, HS), SR_Cont encodings, the instruction-field bit positions, and the FSM state enum.
REQ-036 The register file SHALL be a sub-module named alu_regfile, with 2 read ports, 1 debug read port, 1 write port, and asynchronous reset.
REQ-037 The ALU itself SHALL be external to this block.

Verification
REQ-038 Reset, then MOVI R1,0x0005 and MOVI R2,0x0003 -> each gives done at cycle 3 with wrote=1; dbg R1=5, R2=3.
REQ-039 ADD R3,R1,R2 with S=1 (ALU model returns 8, flags 0000) -> R3=8, flags_q=0000, wrote=1.
REQ-040 CMP R1,R2 -> wrote=0, flags_q updated from ALU, R0-R15 unchanged.
REQ-041 Cond=EQ with R1=5, R2=3 (cond_met=0) -> done=1, wrote=0, Rd and flags_q unchanged.
REQ-042 Opcode 1111 -> done=1, illegal=1, no state change; instr_valid held high through cycles 1-3 -> no second accept until cycle 4.
REQ-043 rst_n pulsed low in EXEC of ADD R4 -> no done, R4=0, instr_ready=1 after release.
